// File: rtl/fixed_point_divider_if.sv
// Start/done handshake bundle for the iterative fixed-point divider.
// The master modport drives operands and start; the slave modport returns the result.
interface fixed_point_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic             ovf;
  logic             dz;

  modport master (
    output start, data0, data1,
    input  ready, done, quot, ovf, dz
  );

  modport slave (
    input  start, data0, data1,
    output ready, done, quot, ovf, dz
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Iterative signed Q(WIDTH-FRAC_SIZE).FRAC_SIZE divider, one quotient bit per clock, with saturation.
// FIXED_POINT_DIVIDER_ROUND_NEAREST_EN adds a guard iteration and rounds half away from zero.
module fixed_point_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_SIZE = 30
) (
  input logic                  clk,
  input logic                  rst,
  fixed_point_divider_if.slave bus
);

`ifdef FIXED_POINT_DIVIDER_ROUND_NEAREST_EN
  localparam int N = WIDTH + FRAC_SIZE + 1;
`else
  localparam int N = WIDTH + FRAC_SIZE;
`endif
  localparam int CW = $clog2(N + 1);
  localparam int SH = N - WIDTH;

  localparam logic [N-1:0]     MAG_MAX_POS = N'({(WIDTH-1){1'b1}});
  localparam logic [N-1:0]     MAG_MAX_NEG = MAG_MAX_POS + N'(1);
  localparam logic [WIDTH-1:0] Q_MAX       = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN       = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic             neg0_q, neg0_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH:0]   mag1_q, mag1_d;
  logic [N-1:0]     div_q, div_d;
  logic [WIDTH+1:0] rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag0_in;
  logic [WIDTH-1:0] mag1_in;
  logic [WIDTH+2:0] rem_sh;
  logic [WIDTH+2:0] div_ext;
  logic             rem_ge;
  logic [N-1:0]     mag;
  logic             over;

  // A W-bit unsigned negate is exact even for the most negative operand.
  always_comb begin
    mag0_in = bus.data0[WIDTH-1] ? ('0 - bus.data0) : bus.data0;
    mag1_in = bus.data1[WIDTH-1] ? ('0 - bus.data1) : bus.data1;
    rem_sh  = {rem_q, div_q[N-1]};
    div_ext = (WIDTH+3)'(mag1_q);
    rem_ge  = (rem_sh >= div_ext);
`ifdef FIXED_POINT_DIVIDER_ROUND_NEAREST_EN
    mag     = {1'b0, quo_q[N-1:1]} + N'(quo_q[0]);
`else
    mag     = quo_q;
`endif
    over    = sign_q ? (mag > MAG_MAX_NEG) : (mag > MAG_MAX_POS);
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    neg0_d    = neg0_q;
    dz_pend_d = dz_pend_q;
    mag1_d    = mag1_q;
    div_d     = div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d    = bus.data0[WIDTH-1] ^ bus.data1[WIDTH-1];
          neg0_d    = bus.data0[WIDTH-1];
          mag1_d    = {1'b0, mag1_in};
          div_d     = {mag0_in, {SH{1'b0}}};
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CW'(N);
          dz_pend_d = (bus.data1 == '0);
          state_d   = (bus.data1 == '0) ? FIX : DIV;
        end
      end

      DIV: begin
        rem_d = rem_ge ? (WIDTH+2)'(rem_sh - div_ext) : rem_sh[WIDTH+1:0];
        quo_d = {quo_q[N-2:0], rem_ge};
        div_d = div_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_pend_q) begin
          quot_d = neg0_q ? Q_MIN : Q_MAX;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else if (over) begin
          quot_d = sign_q ? Q_MIN : Q_MAX;
          ovf_d  = 1'b1;
          dz_d   = 1'b0;
        end else begin
          // A zero magnitude negates to zero, so no negative-zero case exists.
          quot_d = sign_q ? ('0 - mag[WIDTH-1:0]) : mag[WIDTH-1:0];
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      neg0_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      mag1_q    <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      neg0_q    <= neg0_d;
      dz_pend_q <= dz_pend_d;
      mag1_q    <= mag1_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.quot  = quot_q;
  assign bus.ovf   = ovf_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: stimulus pushes expected results, a monitor checks each done.
module tb_fixed_point_divider;

`ifdef FIXED_POINT_DIVIDER_ROUND_NEAREST_EN
  localparam int LAT = 64;
  localparam logic [31:0] Q_2_3   = 32'h2AAAAAAB;
  localparam logic [31:0] Q_M2_3  = 32'hD5555555;
`else
  localparam int LAT = 63;
  localparam logic [31:0] Q_2_3   = 32'h2AAAAAAA;
  localparam logic [31:0] Q_M2_3  = 32'hD5555556;
`endif

  typedef struct {
    string       name;
    logic [31:0] q;
    logic        o;
    logic        z;
    int          k;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  fixed_point_divider_if #(.WIDTH(32)) bus ();

  fixed_point_divider #(.WIDTH(32), .FRAC_SIZE(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done quot=0x%08h", bus.quot);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s quot=0x%08h ovf=%0b dz=%0b lat=%0d", e.name, bus.quot, bus.ovf, bus.dz, cyc - e.k);
        chk({e.name, "_quot"}, bus.quot, e.q);
        chk({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.o));
        chk({e.name, "_dz"}, 32'(bus.dz), 32'(e.z));
        chk({e.name, "_lat"}, 32'(cyc - e.k), 32'(e.lat));
      end
    end
  end

  // Called at a negedge: drives a start that the next rising edge samples.
  task automatic issue(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] eq, input logic eo, input logic ez, input int lat);
    exp_t e;
    e.name = nm; e.q = eq; e.o = eo; e.z = ez; e.k = cyc + 1; e.lat = lat;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.data0 = d0;
    bus.data1 = d1;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] eq, input logic eo, input logic ez, input int lat);
    issue(nm, d0, d1, eq, eo, ez, lat);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(nm);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_done",  32'(bus.done),  32'd0);
    chk("reset_quot",  bus.quot,       32'd0);
    chk("reset_ovf",   32'(bus.ovf),   32'd0);
    chk("reset_dz",    32'(bus.dz),    32'd0);

    run("neg_eighth_by_half", 32'hF8000000, 32'h20000000, 32'hF0000000, 1'b0, 1'b0, LAT);
    run("quarter_by_neg_half", 32'h10000000, 32'hE0000000, 32'hE0000000, 1'b0, 1'b0, LAT);
    run("neg_half_by_neg_half", 32'hE0000000, 32'hE0000000, 32'h40000000, 1'b0, 1'b0, LAT);
    run("sat_pos_6", 32'h60000000, 32'h10000000, 32'h7FFFFFFF, 1'b1, 1'b0, LAT);
    run("sat_neg2_by_neg1", 32'h80000000, 32'hC0000000, 32'h7FFFFFFF, 1'b1, 1'b0, LAT);
    run("neg2_by_one", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, LAT);
    run("sat_neg4", 32'h80000000, 32'h20000000, 32'h80000000, 1'b1, 1'b0, LAT);
    run("dz_neg", 32'hC0000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1);
    run("dz_zero_zero", 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
    run("zero_by_neg", 32'h00000000, 32'hA0000000, 32'h00000000, 1'b0, 1'b0, LAT);
    run("max_by_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h40000000, 1'b0, 1'b0, LAT);
    run("one_by_1p5", 32'h40000000, 32'h60000000, Q_2_3, 1'b0, 1'b0, LAT);
    run("neg1_by_1p5", 32'hC0000000, 32'h60000000, Q_M2_3, 1'b0, 1'b0, LAT);

    // A start raised while busy must be dropped.
    issue("busy_main", 32'hF8000000, 32'h20000000, 32'hF0000000, 1'b0, 1'b0, LAT);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b1;
    bus.data0 = 32'h7FFFFFFF;
    bus.data1 = 32'h00000001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_main");

    // Reset in the middle of a division aborts it with no done.
    issue("aborted", 32'h10000000, 32'hE0000000, 32'hE0000000, 1'b0, 1'b0, LAT);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_quot",  bus.quot,       32'd0);
    chk("abort_done",  32'(bus.done),  32'd0);
    repeat (80) @(negedge clk);

    run("after_reset", 32'h10000000, 32'hE0000000, 32'hE0000000, 1'b0, 1'b0, LAT);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Iterative signed fixed-point divider; arithmetic inverse of the Q(WIDTH-FRAC_SIZE).FRAC_SIZE multiplier in the CNN datapath.
- Default format is Q2.30.
- Used for normalisation and scaling stages where a reciprocal or quotient is needed.
- Produces one quotient bit per clock under a start/done handshake, with saturation and divide-by-zero flagging.

Parameters:
- WIDTH, 32, total bits of operands and quotient (two's complement).
- FRAC_SIZE, 30, fractional bits of operands and quotient.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- data0  input  WIDTH  signed dividend; captured on the start cycle.
- data1  input  WIDTH  signed divisor; captured on the start cycle.
- ready  output  1  high in IDLE; start is accepted.
- done  output  1  one-cycle pulse; quot/ovf/dz valid.
- quot  output  WIDTH  signed quotient = data0/data1 in the same Q format.
- ovf  output  1  result saturated (magnitude out of range).
- dz  output  1  divisor was zero.

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: ready=1, done=0, quot=0, ovf=0, dz=0; FSM goes to IDLE.
- Reset mid-operation aborts the division. No done is produced.
- FSM states: IDLE, DIV, FIX.
- IDLE, start=1, data1!=0:
  - Latch sign = data0[MSB]^data1[MSB].
  - Latch magnitudes |data0| and |data1| as WIDTH+1-bit unsigned, so that -2^(WIDTH-1) is exact.
  - Dividend register = |data0| << FRAC_SIZE.
  - Clear remainder. Set iteration counter to N = WIDTH+FRAC_SIZE (62 by default). ready goes 0. Go to DIV.
- IDLE, start=1, data1==0: go directly to FIX with dz pending. Operand registers still load.
- DIV: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Counter decrements each cycle. Go to FIX after the last iteration.
- FIX (one cycle):
  - Overflow if the unsigned quotient magnitude exceeds 2^(WIDTH-1)-1 (positive result) or 2^(WIDTH-1) (negative result).
  - Normal case: quot = sign ? -mag : mag, truncated toward zero.
  - Overflow case: quot = 0x7FF..F (positive) or 0x800..0 (negative), ovf=1.
  - Divide by zero: dz=1, ovf=0. quot = 0x800..0 if data0<0, otherwise 0x7FF..F (including 0/0).
  - Zero dividend with nonzero divisor gives quot=0, with no negative-zero artefacts.
  - done=1 this cycle only. Return to IDLE with ready=1.
- Latency, start sampled at edge k:
  - Normal: done high after edge k+N+1 (63 edges by default).
  - Divide by zero: done high after edge k+1.
- start while ready=0 is ignored; no queueing.
- quot, ovf and dz hold until the next done, or until reset. ovf and dz update only in FIX.
- A new start may be accepted in the cycle immediately after done, since ready=1 in that cycle.
- Widths:
  - Remainder is WIDTH+2 bits.
  - Quotient shift register is N bits.
  - No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIXED_POINT_DIVIDER_ROUND_NEAREST_EN.
- Defined:
  - One extra DIV iteration produces a guard bit, so N = WIDTH+FRAC_SIZE+1 and latency is N+1.
  - FIX adds the guard bit to the magnitude: round half away from zero.
  - The saturation check is applied after rounding.
- Undefined: truncation toward zero. Latency is as stated above.

Test Plan:
- data0=0xF8000000 (-0.125), data1=0x20000000 (0.5) -> quot=0xF0000000 (-0.25), ovf=0, dz=0; done exactly 63 edges after the start edge.
- data0=0x10000000 (0.25), data1=0xE0000000 (-0.5) -> quot=0xE0000000 (-0.5). Then data0=0xE0000000, data1=0xE0000000 -> quot=0x40000000 (1.0).
- Saturation:
  - data0=0x60000000 (1.5), data1=0x10000000 (0.25) -> quot=0x7FFFFFFF, ovf=1.
  - data0=0x80000000 (-2.0), data1=0xC0000000 (-1.0) -> quot=0x7FFFFFFF, ovf=1.
- Divide by zero: data0=0xC0000000, data1=0 -> quot=0x80000000, dz=1, ovf=0; done one edge after start.
- Handshake and reset:
  - start pulsed at cycle 10 while busy -> ignored, single done.
  - rst asserted at iteration 20 -> no done; ready=1, quot=0 next cycle.
  - A fresh divide started afterwards is correct.
- data0=0x40000000 (1.0), data1=0x60000000 (1.5):
  - Macro undefined -> quot=0x2AAAAAAA.
  - Macro defined -> quot=0x2AAAAAAB; done 64 edges after the start edge.
